// File: rtl/fpm_arbiter.sv
// Round-robin arbiter that time-shares one combinational single-precision multiplier.
// Operands and the product are both registered, so the long multiply path is bounded by flops.
module fpm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_result,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] grant_id_reg;
  logic [31:0]    op_a_reg;
  logic [31:0]    op_b_reg;
  logic [31:0]    resp_result_reg;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Truncating multiplier: no rounding, exponent wraps modulo 256.
  logic [7:0]  ea, eb, exp_res;
  logic [23:0] sig_a, sig_b;
  logic [47:0] prod;
  logic [24:0] prod_top;
  logic [22:0] mant_res;
  logic        zero_op;
  logic [31:0] fpm_result;

  assign ea       = op_a_reg[30:23];
  assign eb       = op_b_reg[30:23];
  assign sig_a    = {1'b1, op_a_reg[22:0]};
  assign sig_b    = {1'b1, op_b_reg[22:0]};
  assign prod     = 48'(sig_a) * 48'(sig_b);
  assign prod_top = 25'(prod >> 23);
  assign mant_res = prod_top[24] ? prod_top[23:1] : prod_top[22:0];
  assign exp_res  = ea + eb + {7'b0, prod_top[24]} - 8'd127;
  assign zero_op  = (op_a_reg[30:0] == 31'd0) || (op_b_reg[30:0] == 31'd0);
  assign fpm_result = zero_op ? 32'h0000_0000
                              : {op_a_reg[31] ^ op_b_reg[31], exp_res, mant_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      resp_result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            op_a_reg     <= req_a[32*int'(win_idx) +: 32];
            op_b_reg     <= req_b[32*int'(win_idx) +: 32];
            grant_id_reg <= win_idx;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          resp_result_reg <= fpm_result;
          state_reg       <= RESP;
        end
        RESP: begin
          if (resp_ready[grant_id_reg]) begin
            rr_ptr_reg <= (grant_id_reg == IDW'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign req_ready[gi]  = (state_reg == IDLE) && win_found && (win_idx == IDW'(gi));
    assign resp_valid[gi] = (state_reg == RESP) && (grant_id_reg == IDW'(gi));
  end

  assign resp_result = resp_result_reg;
  assign grant_id    = grant_id_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_fpm_arbiter.sv
// Directed bench for fpm_arbiter: arithmetic vector table plus arbitration, backpressure and reset sequences.
module tb_fpm_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [31:0]    resp_result;
  logic [1:0]     grant_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  fpm_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_val);
    checks++;
    if (act !== exp_val) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_val);
    end
  endtask

  task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction from IDLE; handshake cycle T, response expected at T+2.
  task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected);
    drive(idx, a, b);
    req_valid = N'(1 << idx);
    #1;
    chk("req_ready", 32'(req_ready), 32'(1 << idx));
    cyc();
    req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_no_resp", 32'(resp_valid), 32'd0);
    cyc();
    chk("resp_valid", 32'(resp_valid), 32'(1 << idx));
    chk("result", resp_result, expected);
    chk("grant_id", 32'(grant_id), 32'(idx));
    $display("txn req=%0d a=%h b=%h result=%h expected=%h", idx, a, b, resp_result, expected);
    resp_ready = N'(1 << idx);
    cyc();
    resp_ready = '0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    vecs[1] = '{1, 32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000};
    vecs[2] = '{2, 32'h0000_0000, 32'hC040_0000, 32'h0000_0000};
    vecs[3] = '{3, 32'h8000_0000, 32'hC040_0000, 32'h0000_0000};
    vecs[4] = '{0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    vecs[5] = '{1, 32'hC080_0000, 32'h40A0_0000, 32'hC1A0_0000};
    vecs[6] = '{2, 32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000};
    vecs[7] = '{3, 32'h0000_0001, 32'h3F80_0000, 32'h0000_0001};
    vecs[8] = '{0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE};

    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    do_reset();

    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Arithmetic vectors
    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].expected);

    // Round-robin with all requesters held valid from reset: order 0,1,2,3,0
    for (int i = 0; i < N; i++) drive(i, 32'h3F80_0000, 32'h4000_0000);
    req_valid = '1;
    do_reset();
    resp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
      $display("txn rr step=%0d req_ready=%b", k, req_ready);
      cyc();
      cyc();
      cyc();
    end
    req_valid  = '0;
    resp_ready = '0;
    #1;

    // rr_ptr=2 (after serving 1) with requests from 0 and 3: grant 3 then 0
    run_txn(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    req_valid  = 4'b1001;
    resp_ready = '1;
    #1;
    chk("rr_ptr2_first", 32'(req_ready), 32'b1000);
    cyc();
    cyc();
    cyc();
    chk("rr_ptr2_second", 32'(req_ready), 32'b0001);
    $display("txn rr_ptr2 second req_ready=%b", req_ready);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    resp_ready = '0;
    #1;

    // Backpressure: hold requester 2 in RESP for 5 cycles with others pending
    drive(2, 32'h4000_0000, 32'h4040_0000);
    req_valid = 4'b0100;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '1;
    cyc();
    for (int c = 0; c < 5; c++) begin
      resp_ready = (c >= 2) ? 4'b1011 : 4'b0000;
      #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'b0100);
      chk("bp_result", resp_result, 32'h40C0_0000);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      cyc();
    end
    resp_ready = 4'b0100;
    cyc();
    resp_ready = '0;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    $display("txn backpressure done next req_ready=%b", req_ready);
    req_valid = '0;
    #1;

    // Reset in EXEC: rr_ptr must return to 0, so grant 1 rather than 3
    run_txn(2, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    drive(3, 32'h4000_0000, 32'h4000_0000);
    req_valid = 4'b1000;
    #1;
    chk("rexec_grant", 32'(req_ready), 32'b1000);
    cyc();
    req_valid = 4'b1010;
    chk("rexec_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rexec_resp_valid", 32'(resp_valid), 32'd0);
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_result", resp_result, 32'd0);
    chk("rexec_next_grant", 32'(req_ready), 32'b0010);
    $display("txn reset_in_exec next req_ready=%b", req_ready);
    req_valid = '0;
    #1;

    // Reset in RESP: rr_ptr must return to 0, so grant 0 rather than 2
    run_txn(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    drive(2, 32'h4000_0000, 32'h4040_0000);
    req_valid = 4'b0100;
    #1;
    cyc();
    req_valid = 4'b0101;
    cyc();
    chk("rresp_in_resp", 32'(resp_valid), 32'b0100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rresp_resp_valid", 32'(resp_valid), 32'd0);
    chk("rresp_busy", 32'(busy), 32'd0);
    chk("rresp_result", resp_result, 32'd0);
    chk("rresp_next_grant", 32'(req_ready), 32'b0001);
    $display("txn reset_in_resp next req_ready=%b", req_ready);
    req_valid = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
